spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- SPI peripheral (responder) end of the link driven by SPI_Master.
- Oversamples SPI_Clk, SPI_CS_n and SPI_MOSI in the Clk domain.
- Deserialises MOSI into bytes and serialises a user-supplied byte onto MISO, MSB first, full duplex.
- Supports back-to-back bytes while CS stays low, with the same SPI_MODE convention as the master.

Parameters:
- SPI_MODE, 3, SPI mode 0-3. CPOL = mode 2 or 3. CPHA = mode 1 or 3.
- IDLE_BYTE, 8'hFF, byte shifted out when no TX byte is queued at a byte start.

Ports:
- Clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- TX_Byte  in  8  byte to return on MISO.
- TX_DataValid  in  1  load pulse for TX_Byte; honoured only when TX_Ready=1.
- TX_Ready  out  1  TX holding register empty.
- TX_Underrun  out  1  1-cycle pulse: IDLE_BYTE was loaded because the holding register was empty.
- RX_DataValid  out  1  1-cycle pulse: RX_Byte holds a complete byte.
- RX_Byte  out  8  last received byte.
- SPI_Clk  in  1  serial clock from the master (asynchronous).
- SPI_CS_n  in  1  active-low chip select (asynchronous).
- SPI_MOSI  in  1  serial data in.
- SPI_MISO  out  1  serial data out.
- SPI_MISO_OE  out  1  MISO output enable: high while the synchronised CS_n is low.

Behaviour:
- Reset values: TX_Ready=0, TX_Underrun=0, RX_DataValid=0, RX_Byte=8'h00, SPI_MISO=0, SPI_MISO_OE=0.
- Internal reset state: synchronisers at idle (CS_n=1, SCK=CPOL), bit count 0, holding register empty.
- TX_Ready rises in the first cycle after reset deasserts.

Synchronisation:
- SPI_Clk, SPI_CS_n and SPI_MOSI each pass a 2-FF synchroniser.
- A third register drives edge detection.
- Pin edge to internal edge pulse = 3 Clk.
- MOSI is delayed identically, so the sampled bit aligns with the SCK edge.
- Requirement: SPI_Clk half-period >= 4 Clk. This matches the master's CLKS_PER_HALF_BIT >= 4 when both ends share Clk.

Edge roles:
- Leading edge = rising if CPOL=0, falling if CPOL=1.
- CPHA=0: sample on leading edge, shift out on trailing edge.
- CPHA=1: shift out on leading edge, sample on trailing edge.
- SCK edges are ignored while synchronised CS_n=1.

States:
- IDLE: waiting for CS_n falling edge.
  - On CS fall, go to ACTIVE with bit count 0.
  - If CPHA=0, perform a byte-start load immediately so the MSB is on MISO before the first leading edge.
- ACTIVE: on each sample edge, shift the synchronised MOSI into the RX shift register and increment bit count (3-bit, wraps 7->0).
  - When the 8th bit is sampled, copy it to RX_Byte and pulse RX_DataValid in the next cycle.
  - Stay in ACTIVE for the next byte.
  - On CS_n rising, go to IDLE.

Byte-start load (TX shift register <= holding register if full, else IDLE_BYTE):
- CPHA=0: at CS fall, and at the trailing edge following the 8th sample.
- CPHA=1: at the first leading edge of each byte.
- The MSB is driven on SPI_MISO the cycle after the load.
- Each subsequent shift edge drives the next lower bit.
- On a load, the holding register empties and TX_Ready rises the next cycle.
- If the holding register was empty, pulse TX_Underrun.

TX handshake:
- TX_DataValid with TX_Ready=1 captures TX_Byte; TX_Ready falls the next cycle.
- TX_DataValid with TX_Ready=0 is ignored (no overwrite).
- A load and a byte-start in the same cycle cannot collide, because load requires TX_Ready=1 (registered).

Boundaries:
- CS_n rises mid-byte: discard the partial byte, no RX_DataValid, clear bit count; the holding register is retained.
- SPI_MISO_OE drops with the synchronised CS_n. SPI_MISO holds its last value.
- reset asserted mid-transfer: everything returns to reset values. Reception restarts only after a fresh CS_n fall.
  - If CS_n is already low when reset deasserts, the synchroniser initial value of 1 makes that a detected fall.
- RX overrun (new byte before the user reads): RX_Byte is overwritten; no flag.

Decomposition:
- Package spi_pkg:
  - function deriving CPOL/CPHA from SPI_MODE;
  - SPI_BYTE_W=8;
  - SPI_SYNC_STAGES=2;
  - FSM state enum {IDLE, ACTIVE}.
- Sub-module spi_input_sync: 2-FF synchroniser plus edge-detect register.
  - Outputs: sync level, rise pulse, fall pulse.
  - Instantiated for SCK and CS_n; MOSI uses the level output only.

Test Plan:
- Mode 3: preload TX_Byte=8'hA5, then drive SPI_Master (CLKS_PER_HALF_BIT=4) sending 8'h3C.
  - Required: slave RX_Byte=8'h3C with one RX_DataValid pulse; master receives 8'hA5.
- Mode 0: repeat the exchange with 8'h81/8'h7E.
  - Required: MSB of 8'h7E appears on SPI_MISO before the first rising SCK; both sides receive correct bytes.
- Three bytes 8'h01, 8'h02, 8'h03 with CS held low; slave refills TX on each TX_Ready.
  - Required: three RX_DataValid pulses in order, TX_Underrun never pulses.
- Second byte with no TX queued (IDLE_BYTE=8'hFF).
  - Required: master receives 8'hFF and TX_Underrun pulses once.
- CS_n deasserted after 5 bits.
  - Required: no RX_DataValid; next full byte 8'hC3 is received correctly.
- reset pulsed for 2 cycles mid-byte.
  - Required: all outputs at reset values; the following CS-framed byte 8'h5A is received intact.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder: mode decoding, widths, FSM states.
package spi_pkg;

  localparam int unsigned SPI_BYTE_W      = 8;
  localparam int unsigned SPI_SYNC_STAGES = 2;

  typedef enum logic {
    IDLE,
    ACTIVE
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_cfg_t;

  function automatic spi_cfg_t spi_mode_cfg(input int unsigned mode);
    spi_cfg_t cfg;
    cfg.cpol = (mode == 2) || (mode == 3);
    cfg.cpha = (mode == 1) || (mode == 3);
    return cfg;
  endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Multi-stage synchroniser for an asynchronous pin, with a trailing register
// that turns level changes into single-cycle rise/fall pulses.
module spi_input_sync
  import spi_pkg::*;
#(
  parameter logic INIT = 1'b1
) (
  input  logic Clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SPI_SYNC_STAGES-1:0] sync_q;
  logic                       prev_q;

  always_ff @(posedge Clk) begin
    if (reset) begin
      sync_q <= {SPI_SYNC_STAGES{INIT}};
      prev_q <= INIT;
    end else begin
      sync_q <= {sync_q[SPI_SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SPI_SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SPI_SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversampled SCK/CS_n/MOSI, full-duplex MSB-first byte transfer
// with a single-entry TX holding register and IDLE_BYTE fill on underrun.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned           SPI_MODE  = 3,
  parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE = 8'hFF
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic [SPI_BYTE_W-1:0] TX_Byte,
  input  logic                  TX_DataValid,
  output logic                  TX_Ready,
  output logic                  TX_Underrun,
  output logic                  RX_DataValid,
  output logic [SPI_BYTE_W-1:0] RX_Byte,
  input  logic                  SPI_Clk,
  input  logic                  SPI_CS_n,
  input  logic                  SPI_MOSI,
  output logic                  SPI_MISO,
  output logic                  SPI_MISO_OE
);

  localparam spi_cfg_t MODE_CFG = spi_mode_cfg(SPI_MODE);
  localparam logic     CPOL     = MODE_CFG.cpol;
  localparam logic     CPHA     = MODE_CFG.cpha;

  logic sck_level, sck_rise, sck_fall;
  logic cs_level, cs_rise, cs_fall;
  logic [SPI_SYNC_STAGES-1:0] mosi_q;

  spi_input_sync #(.INIT(CPOL)) u_sck_sync (
    .Clk      (Clk),
    .reset    (reset),
    .async_in (SPI_Clk),
    .level    (sck_level),
    .rise     (sck_rise),
    .fall     (sck_fall)
  );

  spi_input_sync #(.INIT(1'b1)) u_cs_sync (
    .Clk      (Clk),
    .reset    (reset),
    .async_in (SPI_CS_n),
    .level    (cs_level),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  // Same depth as the SCK path so the sampled bit lines up with the edge pulse.
  always_ff @(posedge Clk) begin
    if (reset) mosi_q <= '0;
    else       mosi_q <= {mosi_q[SPI_SYNC_STAGES-2:0], SPI_MOSI};
  end

  spi_state_t state, state_n;
  logic [2:0]              bit_cnt;
  logic [SPI_BYTE_W-2:0]   rx_shift;
  logic [SPI_BYTE_W-2:0]   tx_shift;
  logic [SPI_BYTE_W-1:0]   hold;
  logic                    hold_full;

  logic sck_edge, leading, trailing, sample_edge, shift_edge;
  logic do_sample, do_load, do_shift, clr_cnt;
  logic tx_capture, hold_full_n;
  logic [SPI_BYTE_W-1:0] rx_next, load_byte;

  assign sck_edge    = (sck_rise | sck_fall) & ~cs_level;
  assign leading     = sck_edge & (sck_level != CPOL);
  assign trailing    = sck_edge & (sck_level == CPOL);
  assign sample_edge = CPHA ? trailing : leading;
  assign shift_edge  = CPHA ? leading : trailing;

  always_ff @(posedge Clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    do_sample = 1'b0;
    do_load   = 1'b0;
    do_shift  = 1'b0;
    clr_cnt   = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_n = ACTIVE;
          clr_cnt = 1'b1;
          do_load = !CPHA;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_n = IDLE;
          clr_cnt = 1'b1;
        end else begin
          do_sample = sample_edge;
          // A shift edge at bit 0 starts a byte: for CPHA=0 that is the trailing
          // edge after the 8th sample, for CPHA=1 the first leading edge.
          if (shift_edge) begin
            if (bit_cnt == 3'd0) do_load  = 1'b1;
            else                 do_shift = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign rx_next     = {rx_shift, mosi_q[SPI_SYNC_STAGES-1]};
  assign load_byte   = hold_full ? hold : IDLE_BYTE;
  assign tx_capture  = TX_DataValid & TX_Ready;
  assign hold_full_n = tx_capture | (hold_full & ~do_load);

  always_ff @(posedge Clk) begin
    if (reset) begin
      bit_cnt      <= '0;
      rx_shift     <= '0;
      RX_Byte      <= '0;
      RX_DataValid <= 1'b0;
      tx_shift     <= '0;
      hold         <= '0;
      hold_full    <= 1'b0;
      TX_Ready     <= 1'b0;
      TX_Underrun  <= 1'b0;
      SPI_MISO     <= 1'b0;
    end else begin
      RX_DataValid <= 1'b0;
      TX_Underrun  <= 1'b0;

      if (clr_cnt) begin
        bit_cnt <= '0;
      end else if (do_sample) begin
        bit_cnt  <= bit_cnt + 3'd1;
        rx_shift <= rx_next[SPI_BYTE_W-2:0];
        if (bit_cnt == 3'd7) begin
          RX_Byte      <= rx_next;
          RX_DataValid <= 1'b1;
        end
      end

      if (do_load) begin
        tx_shift    <= load_byte[SPI_BYTE_W-2:0];
        SPI_MISO    <= load_byte[SPI_BYTE_W-1];
        TX_Underrun <= ~hold_full;
      end else if (do_shift) begin
        tx_shift <= {tx_shift[SPI_BYTE_W-3:0], 1'b0};
        SPI_MISO <= tx_shift[SPI_BYTE_W-2];
      end

      if (tx_capture) hold <= TX_Byte;
      hold_full <= hold_full_n;
      TX_Ready  <= ~hold_full_n;
    end
  end

  assign SPI_MISO_OE = ~cs_level;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench: a behavioural SPI master (4 Clk per half bit) exercises a mode-3
// and a mode-0 responder; expected bytes and pulse counts are hand-computed.
module tb_spi_slave;

  logic       Clk = 1'b0;
  logic       reset;
  logic [7:0] tx_byte;
  logic       tx_dv3, tx_dv0;
  logic       sck, mosi, cs3_n, cs0_n;

  logic       tx_ready3, tx_underrun3, rx_dv3, miso3, oe3;
  logic [7:0] rx_byte3;
  logic       tx_ready0, tx_underrun0, rx_dv0, miso0, oe0;
  logic [7:0] rx_byte0;

  int n_checks = 0;
  int n_fail   = 0;
  int rx3_cnt = 0, rx0_cnt = 0, ur3_cnt = 0, ur0_cnt = 0;
  logic [7:0] rx3_q[$];
  logic [7:0] r, r1, r2, r3;
  int base_rx, base_ur;

  always #5 Clk = ~Clk;

  spi_slave #(.SPI_MODE(3), .IDLE_BYTE(8'hFF)) u_m3 (
    .Clk(Clk), .reset(reset), .TX_Byte(tx_byte), .TX_DataValid(tx_dv3),
    .TX_Ready(tx_ready3), .TX_Underrun(tx_underrun3), .RX_DataValid(rx_dv3),
    .RX_Byte(rx_byte3), .SPI_Clk(sck), .SPI_CS_n(cs3_n), .SPI_MOSI(mosi),
    .SPI_MISO(miso3), .SPI_MISO_OE(oe3)
  );

  spi_slave #(.SPI_MODE(0), .IDLE_BYTE(8'hFF)) u_m0 (
    .Clk(Clk), .reset(reset), .TX_Byte(tx_byte), .TX_DataValid(tx_dv0),
    .TX_Ready(tx_ready0), .TX_Underrun(tx_underrun0), .RX_DataValid(rx_dv0),
    .RX_Byte(rx_byte0), .SPI_Clk(sck), .SPI_CS_n(cs0_n), .SPI_MOSI(mosi),
    .SPI_MISO(miso0), .SPI_MISO_OE(oe0)
  );

  always @(posedge Clk) begin
    if (rx_dv3 === 1'b1) begin
      rx3_cnt++;
      rx3_q.push_back(rx_byte3);
    end
    if (rx_dv0 === 1'b1) rx0_cnt++;
    if (tx_underrun3 === 1'b1) ur3_cnt++;
    if (tx_underrun0 === 1'b1) ur0_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic miso_of(input int unsigned mode);
    return (mode == 0) ? miso0 : miso3;
  endfunction

  function automatic logic ready_of(input int unsigned mode);
    return (mode == 0) ? tx_ready0 : tx_ready3;
  endfunction

  task automatic half_bit();
    repeat (4) @(posedge Clk);
    #1;
  endtask

  task automatic preload(input int unsigned mode, input logic [7:0] b);
    int unsigned k = 0;
    while (ready_of(mode) !== 1'b1 && k < 200) begin
      @(posedge Clk); #1;
      k++;
    end
    check("preload_ready", ready_of(mode), 1);
    tx_byte = b;
    if (mode == 0) tx_dv0 = 1'b1; else tx_dv3 = 1'b1;
    @(posedge Clk); #1;
    tx_dv0 = 1'b0;
    tx_dv3 = 1'b0;
  endtask

  task automatic cs_low(input int unsigned mode, input logic first_bit);
    sck  = (mode >= 2);
    mosi = first_bit;
    repeat (6) @(posedge Clk); #1;
    if (mode == 0) cs0_n = 1'b0; else cs3_n = 1'b0;
  endtask

  task automatic cs_high(input int unsigned mode);
    half_bit();
    half_bit();
    if (mode == 0) cs0_n = 1'b1; else cs3_n = 1'b1;
    repeat (8) @(posedge Clk); #1;
  endtask

  task automatic spi_xfer(input int unsigned mode, input logic [7:0] txb,
                          input int unsigned nbits, output logic [7:0] rxb);
    logic cpol, cpha;
    logic [7:0] acc;
    cpol = (mode >= 2);
    cpha = (mode == 1) || (mode == 3);
    acc  = '0;
    for (int unsigned i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = txb[7-i];
        half_bit();
        acc = {acc[6:0], miso_of(mode)};
        sck = ~cpol;
        half_bit();
        sck = cpol;
      end else begin
        half_bit();
        sck  = ~cpol;
        mosi = txb[7-i];
        half_bit();
        acc = {acc[6:0], miso_of(mode)};
        sck = cpol;
      end
    end
    rxb = acc;
  endtask

  initial begin
    reset = 1'b1; tx_byte = '0; tx_dv3 = 1'b0; tx_dv0 = 1'b0;
    sck = 1'b1; mosi = 1'b0; cs3_n = 1'b1; cs0_n = 1'b1;
    repeat (3) @(posedge Clk); #1;

    check("rst_tx_ready",    tx_ready3, 0);
    check("rst_tx_underrun", tx_underrun3, 0);
    check("rst_rx_dv",       rx_dv3, 0);
    check("rst_rx_byte",     rx_byte3, 8'h00);
    check("rst_miso",        miso3, 0);
    check("rst_miso_oe",     oe3, 0);
    check("rst_m0_oe",       oe0, 0);

    reset = 1'b0;
    @(posedge Clk); #1;
    check("ready_after_reset", tx_ready3, 1);

    // Mode 3 single exchange
    preload(3, 8'hA5);
    check("m3_ready_low_after_load", tx_ready3, 0);
    cs_low(3, 1'b0);
    spi_xfer(3, 8'h3C, 8, r);
    check("m3_oe_during_cs", oe3, 1);
    cs_high(3);
    check("m3_master_rx", r, 8'hA5);
    check("m3_slave_rx", rx_byte3, 8'h3C);
    check("m3_rx_pulses", rx3_cnt, 1);
    check("m3_oe_after_cs", oe3, 0);

    // Mode 0 single exchange; MSB must be on MISO before the first SCK edge
    preload(0, 8'h7E);
    cs_low(0, 1'b1);
    half_bit();
    check("m0_msb_before_sck", miso0, 0);
    check("m0_ready_after_csfall_load", tx_ready0, 1);
    spi_xfer(0, 8'h81, 8, r);
    cs_high(0);
    check("m0_master_rx", r, 8'h7E);
    check("m0_slave_rx", rx_byte0, 8'h81);
    check("m0_rx_pulses", rx0_cnt, 1);
    check("m0_trailing_underrun", ur0_cnt, 1);

    // Three back-to-back bytes with refill on each TX_Ready
    preload(3, 8'h11);
    base_rx = rx3_cnt;
    base_ur = ur3_cnt;
    rx3_q.delete();
    cs_low(3, 1'b0);
    fork
      begin
        spi_xfer(3, 8'h01, 8, r1);
        spi_xfer(3, 8'h02, 8, r2);
        spi_xfer(3, 8'h03, 8, r3);
      end
      begin
        preload(3, 8'h22);
        preload(3, 8'h33);
      end
    join
    cs_high(3);
    check("b2b_master_rx0", r1, 8'h11);
    check("b2b_master_rx1", r2, 8'h22);
    check("b2b_master_rx2", r3, 8'h33);
    check("b2b_rx_pulses", rx3_cnt - base_rx, 3);
    check("b2b_rx_qsize", rx3_q.size(), 3);
    if (rx3_q.size() == 3) begin
      check("b2b_rx0", rx3_q[0], 8'h01);
      check("b2b_rx1", rx3_q[1], 8'h02);
      check("b2b_rx2", rx3_q[2], 8'h03);
    end
    check("b2b_no_underrun", ur3_cnt - base_ur, 0);

    // Second byte with nothing queued
    preload(3, 8'h44);
    base_ur = ur3_cnt;
    cs_low(3, 1'b0);
    spi_xfer(3, 8'h55, 8, r1);
    spi_xfer(3, 8'h66, 8, r2);
    cs_high(3);
    check("ur_first_byte", r1, 8'h44);
    check("ur_idle_byte", r2, 8'hFF);
    check("ur_pulse_count", ur3_cnt - base_ur, 1);
    check("ur_slave_rx", rx_byte3, 8'h66);

    // CS_n released after 5 bits
    base_rx = rx3_cnt;
    cs_low(3, 1'b0);
    spi_xfer(3, 8'hAA, 5, r);
    cs_high(3);
    check("abort_no_rx_pulse", rx3_cnt - base_rx, 0);
    check("abort_rx_byte_kept", rx_byte3, 8'h66);
    preload(3, 8'h96);
    cs_low(3, 1'b0);
    spi_xfer(3, 8'hC3, 8, r);
    cs_high(3);
    check("abort_next_rx", rx_byte3, 8'hC3);
    check("abort_next_pulses", rx3_cnt - base_rx, 1);
    check("abort_next_master_rx", r, 8'h96);

    // Reset pulsed mid-byte
    cs_low(3, 1'b0);
    spi_xfer(3, 8'hF0, 4, r);
    reset = 1'b1;
    @(posedge Clk); #1;
    check("midrst_tx_ready", tx_ready3, 0);
    check("midrst_underrun", tx_underrun3, 0);
    check("midrst_rx_dv", rx_dv3, 0);
    check("midrst_rx_byte", rx_byte3, 8'h00);
    check("midrst_miso", miso3, 0);
    check("midrst_oe", oe3, 0);
    @(posedge Clk); #1;
    reset = 1'b0;
    base_rx = rx3_cnt;
    cs_high(3);
    check("postrst_ready", tx_ready3, 1);
    cs_low(3, 1'b0);
    spi_xfer(3, 8'h5A, 8, r);
    cs_high(3);
    check("postrst_rx", rx_byte3, 8'h5A);
    check("postrst_pulses", rx3_cnt - base_rx, 1);
    check("postrst_master_rx", r, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
